// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// State encoding, default memory geometry and port indices.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker.
// Ports: req/mask in, last_grant in; gnt_valid/gnt_idx out.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic [1:0] eff;

    assign eff = req & ~mask;

    always_comb begin
        gnt_valid = |eff;
        gnt_idx   = PORT_FETCH;
        if (&eff)
            gnt_idx = ~last_grant;
        else if (eff[PORT_DATA])
            gnt_idx = PORT_DATA;
        else
            gnt_idx = PORT_FETCH;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences a single-port byte memory for fetch (0) and data (1).
// Ports: req/we/word/addr/wdata per port, ack0/ack1, rdata, busy, mem_*.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic                word0,
    input  logic                word1,
    input  logic [ADDR_W-1:0]   addr0,
    input  logic [ADDR_W-1:0]   addr1,
    input  logic [2*DATA_W-1:0] wdata0,
    input  logic [2*DATA_W-1:0] wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [2*DATA_W-1:0] rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_datain,
    output logic                mem_write_enable,
    input  logic [DATA_W-1:0]   mem_dataout
);

    state_t state_q;
    state_t state_d;

    logic gnt_valid;
    logic gnt_idx;
    logic last_grant_q;

    logic                lat_we;
    logic                lat_word;
    logic                lat_port;
    logic [ADDR_W-1:0]   lat_addr;
    logic [2*DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0]   rdata_lo_q;
    logic [ADDR_W-1:0]   addr_hold_q;
    logic [DATA_W-1:0]   data_hold_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [2*DATA_W-1:0] rdata_q;

    // A port acked this cycle is masked so a requester that
    // drops req on ack is not granted a second time.
    rr_arbiter2 u_rr (
        .req        ({req1, req0}),
        .mask       ({ack1_q, ack0_q}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (gnt_valid) state_d = ACC0;
            ACC0: state_d = lat_word ? ACC1 : FIN;
            ACC1: state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address and write data hold their last presented value
    // outside the access states.
    always_comb begin
        busy             = (state_q != IDLE);
        mem_address      = addr_hold_q;
        mem_datain       = data_hold_q;
        mem_write_enable = 1'b0;
        unique case (state_q)
            ACC0: begin
                mem_address      = lat_addr;
                mem_datain       = lat_wdata[DATA_W-1:0];
                mem_write_enable = lat_we;
            end
            ACC1: begin
                mem_address      = lat_addr + ADDR_W'(1);
                mem_datain       = lat_wdata[2*DATA_W-1:DATA_W];
                mem_write_enable = lat_we;
            end
            default: begin
                mem_write_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_DATA;
            lat_we       <= 1'b0;
            lat_word     <= 1'b0;
            lat_port     <= PORT_FETCH;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rdata_lo_q   <= '0;
            addr_hold_q  <= '0;
            data_hold_q  <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            addr_hold_q <= mem_address;
            data_hold_q <= mem_datain;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        last_grant_q <= gnt_idx;
                        lat_port     <= gnt_idx;
                        lat_we       <= gnt_idx ? we1 : we0;
                        lat_word     <= gnt_idx ? word1 : word0;
                        lat_addr     <= gnt_idx ? addr1 : addr0;
                        lat_wdata    <= gnt_idx ? wdata1 : wdata0;
                    end
                end
                ACC0: begin
                end
                ACC1: begin
                    rdata_lo_q <= mem_dataout;
                end
                FIN: begin
                    ack0_q <= (lat_port == PORT_FETCH);
                    ack1_q <= (lat_port == PORT_DATA);
                    if (!lat_word)
                        rdata_lo_q <= mem_dataout;
                    if (!lat_we) begin
                        if (lat_word)
                            rdata_q <= {mem_dataout, rdata_lo_q};
                        else
                            rdata_q <= {{DATA_W{1'b0}}, mem_dataout};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4096x8 memory.
// Checks latency, write strobes, wrap, round-robin and reset abort.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, word0, word1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [15:0] rdata;
    logic [11:0] mem_address;
    logic [7:0]  mem_datain;
    logic        mem_write_enable;
    logic [7:0]  mem_dataout;

    logic [7:0]  mem [0:4095];
    logic        preload;

    int errors;
    int checks;

    mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req0             (req0),
        .req1             (req1),
        .we0              (we0),
        .we1              (we1),
        .word0            (word0),
        .word1            (word1),
        .addr0            (addr0),
        .addr1            (addr1),
        .wdata0           (wdata0),
        .wdata1           (wdata1),
        .ack0             (ack0),
        .ack1             (ack1),
        .rdata            (rdata),
        .busy             (busy),
        .mem_address      (mem_address),
        .mem_datain       (mem_datain),
        .mem_write_enable (mem_write_enable),
        .mem_dataout      (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'hC3;
        end else begin
            if (mem_write_enable) mem[mem_address] <= mem_datain;
            mem_dataout <= mem[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic port, input logic we, input logic word,
                        input logic [11:0] a, input logic [15:0] wd,
                        output int lat, output int wecnt,
                        output logic [11:0] wa0, output logic [11:0] wa1);
        logic done;
        if (port) begin
            we1 = we; word1 = word; addr1 = a; wdata1 = wd; req1 = 1'b1;
        end else begin
            we0 = we; word0 = word; addr0 = a; wdata0 = wd; req0 = 1'b1;
        end
        lat = 0; wecnt = 0; wa0 = '0; wa1 = '0; done = 1'b0;
        while (!done && lat < 10) begin
            step();
            lat++;
            if (mem_write_enable) begin
                if (wecnt == 0) wa0 = mem_address;
                else wa1 = mem_address;
                wecnt++;
            end
            if (port ? ack1 : ack0) done = 1'b1;
        end
        chk("xfer_ack_seen", {31'd0, done}, 32'd1);
        chk("xfer_other_ack", {31'd0, port ? ack0 : ack1}, 32'd0);
        chk("xfer_busy_in_ack", {31'd0, busy}, 32'd0);
        if (port) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wecnt, k;
        logic [11:0] wa0, wa1;
        logic order [0:2];
        errors = 0; checks = 0;
        rst_n = 1'b0; preload = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; word0 = 0; word1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        step();
        preload = 1'b0;
        step();
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_addr", {20'd0, mem_address}, 32'd0);
        chk("rst_datain", {24'd0, mem_datain}, 32'd0);
        rst_n = 1'b1;
        step();

        xfer(1'b1, 1'b1, 1'b0, 12'h010, 16'h005A, lat, wecnt, wa0, wa1);
        chk("bw_latency", lat, 32'd3);
        chk("bw_we_cycles", wecnt, 32'd1);
        chk("bw_we_addr", {20'd0, wa0}, 32'h010);
        chk("bw_mem", {24'd0, mem[12'h010]}, 32'h5A);
        step();

        xfer(1'b0, 1'b0, 1'b0, 12'h010, 16'h0000, lat, wecnt, wa0, wa1);
        chk("br_latency", lat, 32'd3);
        chk("br_we_cycles", wecnt, 32'd0);
        chk("br_rdata", {16'd0, rdata}, 32'h005A);
        step();

        xfer(1'b1, 1'b1, 1'b1, 12'hFFF, 16'hBEEF, lat, wecnt, wa0, wa1);
        chk("ww_latency", lat, 32'd4);
        chk("ww_we_cycles", wecnt, 32'd2);
        chk("ww_addr_lo", {20'd0, wa0}, 32'hFFF);
        chk("ww_addr_wrap", {20'd0, wa1}, 32'h000);
        chk("ww_mem_fff", {24'd0, mem[12'hFFF]}, 32'hEF);
        chk("ww_mem_000", {24'd0, mem[12'h000]}, 32'hBE);
        chk("ww_rdata_held", {16'd0, rdata}, 32'h005A);
        step();

        xfer(1'b0, 1'b0, 1'b1, 12'hFFF, 16'h0000, lat, wecnt, wa0, wa1);
        chk("wr_latency", lat, 32'd4);
        chk("wr_rdata", {16'd0, rdata}, 32'hBEEF);
        step();

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        we0 = 0; word0 = 0; addr0 = 12'h010;
        we1 = 0; word1 = 0; addr1 = 12'hFFF;
        req0 = 1'b1; req1 = 1'b1;
        k = 0; lat = 0;
        while (k < 3 && lat < 15) begin
            step();
            lat++;
            if (ack0 || ack1) begin
                chk("rr_single_ack", {31'd0, ack0 & ack1}, 32'd0);
                chk("rr_busy_ack", {31'd0, busy}, 32'd0);
                order[k] = ack1;
                k++;
            end else begin
                chk("rr_busy_active", {31'd0, busy}, 32'd1);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_three_acks", k, 32'd3);
        chk("rr_order", {29'd0, order[0], order[1], order[2]}, 32'b010);
        step();
        step();

        we1 = 0; word1 = 0; addr1 = 12'h010; req1 = 1'b1;
        lat = 0;
        while (!ack1 && lat < 10) begin
            step();
            lat++;
        end
        chk("hold_first_latency", lat, 32'd3);
        step();
        chk("hold_no_regrant", {31'd0, busy}, 32'd0);
        chk("hold_ack_pulse", {31'd0, ack1}, 32'd0);
        step();
        chk("hold_regrant", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!ack1 && lat < 10) begin
            step();
            lat++;
        end
        req1 = 1'b0;
        chk("hold_second_ack", {31'd0, ack1}, 32'd1);
        chk("hold_rdata", {16'd0, rdata}, 32'h005A);
        step();

        we1 = 1; word1 = 1; addr1 = 12'h100; wdata1 = 16'h1234;
        req1 = 1'b1;
        step();
        chk("abort_acc0_we", {31'd0, mem_write_enable}, 32'd1);
        chk("abort_acc0_addr", {20'd0, mem_address}, 32'h100);
        step();
        chk("abort_acc1_we", {31'd0, mem_write_enable}, 32'd1);
        chk("abort_acc1_addr", {20'd0, mem_address}, 32'h101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, mem_write_enable}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rdata", {16'd0, rdata}, 32'd0);
        step();
        chk("abort_no_ack", {30'd0, ack1, ack0}, 32'd0);
        req1 = 1'b0;
        step();
        chk("abort_mem_lo", {24'd0, mem[12'h100]}, 32'h34);
        chk("abort_mem_hi", {24'd0, mem[12'h101]}, 32'hC3);
        rst_n = 1'b1;
        step();
        step();
        chk("abort_idle_after", {29'd0, busy, ack1, ack0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
